// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with trap entry/return sequencing for a single hart.
// Traps and mret produce a one-cycle redirect pulse toward the fetch unit.
module csr_trap_unit #(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] HARTID    = {XLEN{1'b0}},
  parameter logic [XLEN-1:0] MTVEC_RST = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      csr_op_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_illegal_o,
  input  logic            retire_i,
  input  logic            exc_valid_i,
  input  logic [3:0]      exc_cause_i,
  input  logic [XLEN-1:0] exc_pc_i,
  input  logic [XLEN-1:0] exc_tval_i,
  input  logic            mret_i,
  input  logic            int_ok_i,
  input  logic [XLEN-1:0] int_pc_i,
  input  logic            msip_i,
  input  logic            mtip_i,
  input  logic            meip_i,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            int_taken_o
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  localparam logic [XLEN-1:0] IRQ_MASK = {{(XLEN-12){1'b0}}, 12'h888};
  localparam logic [XLEN-1:0] ONE      = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_mstatus_mie;
  logic            r_mstatus_mpie;
  logic [XLEN-1:0] r_mie;
  logic [XLEN-1:0] r_mip;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] r_mtval;
  logic [XLEN-1:0] r_mcycle;
  logic [XLEN-1:0] r_minstret;
  logic            r_redirect_valid;
  logic [XLEN-1:0] r_redirect_pc;
  logic            r_int_taken;

  logic [XLEN-1:0] w_mstatus_rd;
  logic [XLEN-1:0] w_old;
  logic [XLEN-1:0] w_new;
  logic            w_legal_addr;
  logic            w_readonly;
  logic            w_wr_req;
  logic [XLEN-1:0] w_irq;
  logic            w_pending;
  logic [3:0]      w_int_code;
  logic            w_idle;
  logic            w_exc_take;
  logic            w_int_take;
  logic            w_mret_take;
  logic            w_csr_we;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_target;
  logic            w_redirect_valid_nxt;
  logic [XLEN-1:0] w_redirect_pc_nxt;
  logic            w_int_taken_nxt;

  // MPP is hardwired to machine mode, so only MIE/MPIE are stored.
  assign w_mstatus_rd = {{(XLEN-13){1'b0}}, 2'b11, 3'b000, r_mstatus_mpie,
                         3'b000, r_mstatus_mie, 3'b000};

  // CSR read mux, address decode and read-only classification.
  always_comb begin
    w_old        = ZERO;
    w_legal_addr = 1'b1;
    w_readonly   = 1'b0;
    case (csr_addr_i)
      A_MSTATUS:  w_old = w_mstatus_rd;
      A_MIE:      w_old = r_mie;
      A_MTVEC:    w_old = r_mtvec;
      A_MEPC:     w_old = r_mepc;
      A_MCAUSE:   w_old = r_mcause;
      A_MTVAL:    w_old = r_mtval;
      A_MIP:      begin w_old = r_mip;  w_readonly = 1'b1; end
      A_MCYCLE:   w_old = r_mcycle;
      A_MINSTRET: w_old = r_minstret;
      A_MHARTID:  begin w_old = HARTID; w_readonly = 1'b1; end
      default:    w_legal_addr = 1'b0;
    endcase
  end

  // Read-modify-write value and whether the op actually writes.
  always_comb begin
    w_new    = w_old;
    w_wr_req = 1'b0;
    case (csr_op_i)
      2'b01:   begin w_new = csr_wdata_i;          w_wr_req = 1'b1; end
      2'b10:   begin w_new = w_old | csr_wdata_i;  w_wr_req = (csr_wdata_i != ZERO); end
      2'b11:   begin w_new = w_old & ~csr_wdata_i; w_wr_req = (csr_wdata_i != ZERO); end
      default: begin w_new = w_old;                w_wr_req = 1'b0; end
    endcase
  end

  assign csr_rdata_o = w_old;

  // Illegal access is reported regardless of FSM state or competing events.
  always_comb begin
    if (csr_op_i != 2'b00) begin
      csr_illegal_o = ~w_legal_addr | (w_readonly & w_wr_req);
    end else begin
      csr_illegal_o = 1'b0;
    end
  end

  assign w_irq     = r_mie & r_mip;
  assign w_pending = r_mstatus_mie & (|w_irq);

  // Interrupt cause selection: external, then software, then timer.
  always_comb begin
    if (w_irq[11]) begin
      w_int_code = 4'd11;
    end else if (w_irq[3]) begin
      w_int_code = 4'd3;
    end else begin
      w_int_code = 4'd7;
    end
  end

  assign w_idle      = (r_state == ST_IDLE);
  assign w_exc_take  = w_idle & exc_valid_i;
  assign w_int_take  = w_idle & w_pending & int_ok_i & ~exc_valid_i;
  assign w_mret_take = w_idle & mret_i & ~exc_valid_i & ~w_int_take;
  assign w_csr_we    = w_idle & w_wr_req & ~csr_illegal_o & ~exc_valid_i
                     & ~w_int_take & ~mret_i;

  assign w_base = {r_mtvec[XLEN-1:2], 2'b00};

  // Redirect target: vectored mode only applies to interrupts.
  always_comb begin
    if (w_exc_take) begin
      w_target = w_base;
    end else if (w_int_take) begin
      if (r_mtvec[0]) begin
        w_target = w_base + {{(XLEN-6){1'b0}}, w_int_code, 2'b00};
      end else begin
        w_target = w_base;
      end
    end else begin
      w_target = r_mepc;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and next redirect outputs.
  always_comb begin
    w_state_nxt          = r_state;
    w_redirect_valid_nxt = 1'b0;
    w_redirect_pc_nxt    = r_redirect_pc;
    w_int_taken_nxt      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_exc_take | w_int_take | w_mret_take) begin
          w_state_nxt          = ST_REDIRECT;
          w_redirect_valid_nxt = 1'b1;
          w_redirect_pc_nxt    = w_target;
          w_int_taken_nxt      = w_int_take;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REDIRECT: w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered redirect outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= ZERO;
      r_int_taken      <= 1'b0;
    end else begin
      r_redirect_valid <= w_redirect_valid_nxt;
      r_redirect_pc    <= w_redirect_pc_nxt;
      r_int_taken      <= w_int_taken_nxt;
    end
  end

  assign redirect_valid_o = r_redirect_valid;
  assign redirect_pc_o    = r_redirect_pc;
  assign int_taken_o      = r_int_taken;

  // Interrupt line sampling and free-running counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mip      <= ZERO;
      r_mcycle   <= ZERO;
      r_minstret <= ZERO;
    end else begin
      r_mip <= {{(XLEN-12){1'b0}}, meip_i, 3'b000, mtip_i, 3'b000, msip_i, 3'b000};
      if (w_csr_we && (csr_addr_i == A_MCYCLE)) begin
        r_mcycle <= w_new;
      end else begin
        r_mcycle <= r_mcycle + ONE;
      end
      if (w_csr_we && (csr_addr_i == A_MINSTRET)) begin
        r_minstret <= w_new;
      end else if (retire_i) begin
        r_minstret <= r_minstret + ONE;
      end else begin
        r_minstret <= r_minstret;
      end
    end
  end

  // Trap entry, mret and software writes to the trap CSRs, in priority order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= ZERO;
      r_mtvec        <= MTVEC_RST;
      r_mepc         <= ZERO;
      r_mcause       <= ZERO;
      r_mtval        <= ZERO;
    end else if (w_exc_take) begin
      r_mepc         <= exc_pc_i & ~ONE;
      r_mcause       <= {1'b0, {(XLEN-5){1'b0}}, exc_cause_i};
      r_mtval        <= exc_tval_i;
      r_mstatus_mpie <= r_mstatus_mie;
      r_mstatus_mie  <= 1'b0;
    end else if (w_int_take) begin
      r_mepc         <= int_pc_i & ~ONE;
      r_mcause       <= {1'b1, {(XLEN-5){1'b0}}, w_int_code};
      r_mtval        <= ZERO;
      r_mstatus_mpie <= r_mstatus_mie;
      r_mstatus_mie  <= 1'b0;
    end else if (w_mret_take) begin
      r_mstatus_mie  <= r_mstatus_mpie;
      r_mstatus_mpie <= 1'b1;
    end else if (w_csr_we) begin
      case (csr_addr_i)
        A_MSTATUS: begin
          r_mstatus_mie  <= w_new[3];
          r_mstatus_mpie <= w_new[7];
        end
        A_MIE:    r_mie    <= w_new & IRQ_MASK;
        A_MTVEC:  r_mtvec  <= {w_new[XLEN-1:2], 1'b0, w_new[0]};
        A_MEPC:   r_mepc   <= w_new & ~ONE;
        A_MCAUSE: r_mcause <= w_new;
        A_MTVAL:  r_mtval  <= w_new;
        default:  r_mtval  <= r_mtval;
      endcase
    end else begin
      r_mstatus_mie <= r_mstatus_mie;
    end
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed self-checking bench for csr_trap_unit (XLEN=64, HARTID=5).
module tb_csr_trap_unit;
  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  csr_op_i;
  logic [11:0] csr_addr_i;
  logic [63:0] csr_wdata_i;
  logic [63:0] csr_rdata_o;
  logic        csr_illegal_o;
  logic        retire_i, exc_valid_i, mret_i, int_ok_i;
  logic [3:0]  exc_cause_i;
  logic [63:0] exc_pc_i, exc_tval_i, int_pc_i;
  logic        msip_i, mtip_i, meip_i;
  logic        redirect_valid_o, int_taken_o;
  logic [63:0] redirect_pc_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  csr_trap_unit #(.XLEN(64), .HARTID(64'h5), .MTVEC_RST(64'h0)) dut (
    .clk(clk), .rst(rst),
    .csr_op_i(csr_op_i), .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i),
    .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o),
    .retire_i(retire_i),
    .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i),
    .exc_pc_i(exc_pc_i), .exc_tval_i(exc_tval_i),
    .mret_i(mret_i), .int_ok_i(int_ok_i), .int_pc_i(int_pc_i),
    .msip_i(msip_i), .mtip_i(mtip_i), .meip_i(meip_i),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .int_taken_o(int_taken_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a);
    csr_op_i   = 2'b00;
    csr_addr_i = a;
    #1;
  endtask

  task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [63:0] d);
    csr_op_i    = op;
    csr_addr_i  = a;
    csr_wdata_i = d;
    step();
    csr_op_i    = 2'b00;
    csr_wdata_i = 64'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    csr_op_i = 2'b00; csr_addr_i = 12'h000; csr_wdata_i = 64'h0;
    retire_i = 1'b0; exc_valid_i = 1'b0; exc_cause_i = 4'h0;
    exc_pc_i = 64'h0; exc_tval_i = 64'h0; mret_i = 1'b0;
    int_ok_i = 1'b0; int_pc_i = 64'h0;
    msip_i = 1'b0; mtip_i = 1'b0; meip_i = 1'b0;
    step(); step();
    rst = 1'b0;
    total++; if (redirect_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", redirect_valid_o); end
    rd(A_MSTATUS);
    total++; if (csr_rdata_o !== 64'h1800) begin bad++; $display("FAIL rst_mstatus got=%h want=%h", csr_rdata_o, 64'h1800); end
    rd(A_MCYCLE);
    total++; if (csr_rdata_o !== 64'h0) begin bad++; $display("FAIL rst_mcycle got=%h want=0", csr_rdata_o); end
    rd(A_MHARTID);
    total++; if (csr_rdata_o !== 64'h5) begin bad++; $display("FAIL hartid got=%h want=5", csr_rdata_o); end
    step();
    rd(A_MCYCLE);
    total++; if (csr_rdata_o !== 64'h1) begin bad++; $display("FAIL mcycle_inc got=%h want=1", csr_rdata_o); end
  endtask

  task automatic test_csr_ops();
    wr(2'b01, A_MSTATUS, 64'hFFFF_FFFF);
    rd(A_MSTATUS);
    total++; if (csr_rdata_o !== 64'h1888) begin bad++; $display("FAIL mstatus_rw got=%h want=%h", csr_rdata_o, 64'h1888); end
    wr(2'b11, A_MSTATUS, 64'h8);
    rd(A_MSTATUS);
    total++; if (csr_rdata_o !== 64'h1880) begin bad++; $display("FAIL mstatus_rc got=%h want=%h", csr_rdata_o, 64'h1880); end
    csr_op_i = 2'b10; csr_addr_i = A_MHARTID; csr_wdata_i = 64'h0; #1;
    total++; if (csr_illegal_o !== 1'b0) begin bad++; $display("FAIL hartid_rs0 got=%b want=0", csr_illegal_o); end
    csr_wdata_i = 64'h1; #1;
    total++; if (csr_illegal_o !== 1'b1) begin bad++; $display("FAIL hartid_rs1 got=%b want=1", csr_illegal_o); end
    step();
    rd(A_MHARTID);
    total++; if (csr_rdata_o !== 64'h5) begin bad++; $display("FAIL hartid_kept got=%h want=5", csr_rdata_o); end
    csr_op_i = 2'b01; csr_addr_i = 12'h7C0; csr_wdata_i = 64'h1; #1;
    total++; if (csr_illegal_o !== 1'b1) begin bad++; $display("FAIL bad_addr got=%b want=1", csr_illegal_o); end
    step();
    csr_op_i = 2'b00;
    wr(2'b01, A_MIE, 64'hFFFF_FFFF_FFFF_FFFF);
    wr(2'b01, A_MTVEC, 64'h1003);
    wr(2'b01, A_MEPC, 64'h2001);
    rd(A_MIE);
    total++; if (csr_rdata_o !== 64'h888) begin bad++; $display("FAIL mie_mask got=%h want=%h", csr_rdata_o, 64'h888); end
    rd(A_MTVEC);
    total++; if (csr_rdata_o !== 64'h1001) begin bad++; $display("FAIL mtvec_mask got=%h want=%h", csr_rdata_o, 64'h1001); end
    rd(A_MEPC);
    total++; if (csr_rdata_o !== 64'h2000) begin bad++; $display("FAIL mepc_mask got=%h want=%h", csr_rdata_o, 64'h2000); end
  endtask

  task automatic test_interrupt();
    wr(2'b01, A_MIE, 64'h80);
    mtip_i = 1'b1;
    wr(2'b01, A_MSTATUS, 64'h8);
    rd(A_MIP);
    total++; if (csr_rdata_o !== 64'h80) begin bad++; $display("FAIL mip_sample got=%h want=%h", csr_rdata_o, 64'h80); end
    int_ok_i = 1'b1; int_pc_i = 64'h2000;
    step();
    int_ok_i = 1'b0;
    total++; if (redirect_valid_o !== 1'b1 || int_taken_o !== 1'b1) begin bad++; $display("FAIL int_pulse got=%b%b want=11", redirect_valid_o, int_taken_o); end
    total++; if (redirect_pc_o !== 64'h101C) begin bad++; $display("FAIL int_vector got=%h want=%h", redirect_pc_o, 64'h101C); end
    rd(A_MEPC);
    total++; if (csr_rdata_o !== 64'h2000) begin bad++; $display("FAIL int_mepc got=%h want=%h", csr_rdata_o, 64'h2000); end
    rd(A_MCAUSE);
    total++; if (csr_rdata_o !== 64'h8000_0000_0000_0007) begin bad++; $display("FAIL int_mcause got=%h want=%h", csr_rdata_o, 64'h8000_0000_0000_0007); end
    rd(A_MSTATUS);
    total++; if (csr_rdata_o !== 64'h1880) begin bad++; $display("FAIL int_mstatus got=%h want=%h", csr_rdata_o, 64'h1880); end
    step();
    total++; if (redirect_valid_o !== 1'b0 || int_taken_o !== 1'b0) begin bad++; $display("FAIL int_one_cycle got=%b%b want=00", redirect_valid_o, int_taken_o); end
  endtask

  task automatic test_exception();
    wr(2'b01, A_MSTATUS, 64'h8);
    exc_valid_i = 1'b1; exc_cause_i = 4'd2; exc_pc_i = 64'h3001; exc_tval_i = 64'hDEAD;
    int_ok_i = 1'b1; int_pc_i = 64'h4000;
    csr_op_i = 2'b01; csr_addr_i = A_MTVAL; csr_wdata_i = 64'h1234;
    step();
    exc_valid_i = 1'b0; int_ok_i = 1'b0; csr_op_i = 2'b00;
    total++; if (redirect_valid_o !== 1'b1 || int_taken_o !== 1'b0) begin bad++; $display("FAIL exc_pulse got=%b%b want=10", redirect_valid_o, int_taken_o); end
    total++; if (redirect_pc_o !== 64'h1000) begin bad++; $display("FAIL exc_target got=%h want=%h", redirect_pc_o, 64'h1000); end
    rd(A_MCAUSE);
    total++; if (csr_rdata_o !== 64'h2) begin bad++; $display("FAIL exc_mcause got=%h want=2", csr_rdata_o); end
    rd(A_MTVAL);
    total++; if (csr_rdata_o !== 64'hDEAD) begin bad++; $display("FAIL exc_mtval got=%h want=%h", csr_rdata_o, 64'hDEAD); end
    rd(A_MEPC);
    total++; if (csr_rdata_o !== 64'h3000) begin bad++; $display("FAIL exc_mepc got=%h want=%h", csr_rdata_o, 64'h3000); end
    step();
    mtip_i = 1'b0;
    step();
  endtask

  task automatic test_mret();
    wr(2'b01, A_MEPC, 64'h2000);
    mret_i = 1'b1;
    csr_op_i = 2'b01; csr_addr_i = A_MSTATUS; csr_wdata_i = 64'h0;
    step();
    total++; if (redirect_valid_o !== 1'b1 || int_taken_o !== 1'b0) begin bad++; $display("FAIL mret_pulse got=%b%b want=10", redirect_valid_o, int_taken_o); end
    total++; if (redirect_pc_o !== 64'h2000) begin bad++; $display("FAIL mret_target got=%h want=%h", redirect_pc_o, 64'h2000); end
    step();
    total++; if (redirect_valid_o !== 1'b0) begin bad++; $display("FAIL mret_in_redirect got=%b want=0", redirect_valid_o); end
    mret_i = 1'b0;
    rd(A_MSTATUS);
    total++; if (csr_rdata_o !== 64'h1888) begin bad++; $display("FAIL mret_mstatus got=%h want=%h", csr_rdata_o, 64'h1888); end
  endtask

  task automatic test_back_to_back();
    wr(2'b01, A_MIE, 64'h888);
    msip_i = 1'b1; mtip_i = 1'b1; meip_i = 1'b1;
    step();
    int_ok_i = 1'b1; int_pc_i = 64'h5000;
    step();
    int_ok_i = 1'b0;
    total++; if (redirect_pc_o !== 64'h102C || int_taken_o !== 1'b1) begin bad++; $display("FAIL irq_prio got=%h/%b want=%h/1", redirect_pc_o, int_taken_o, 64'h102C); end
    rd(A_MCAUSE);
    total++; if (csr_rdata_o !== 64'h8000_0000_0000_000B) begin bad++; $display("FAIL irq_prio_cause got=%h want=%h", csr_rdata_o, 64'h8000_0000_0000_000B); end
    msip_i = 1'b0; mtip_i = 1'b0; meip_i = 1'b0;
    step();
    step();
  endtask

  task automatic test_counters();
    wr(2'b01, A_MCYCLE, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(A_MCYCLE);
    total++; if (csr_rdata_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL mcycle_write got=%h want=all-ones", csr_rdata_o); end
    step();
    rd(A_MCYCLE);
    total++; if (csr_rdata_o !== 64'h0) begin bad++; $display("FAIL mcycle_wrap got=%h want=0", csr_rdata_o); end
    retire_i = 1'b1;
    wr(2'b01, A_MINSTRET, 64'h100);
    rd(A_MINSTRET);
    total++; if (csr_rdata_o !== 64'h100) begin bad++; $display("FAIL minstret_write_wins got=%h want=%h", csr_rdata_o, 64'h100); end
    step();
    retire_i = 1'b0;
    rd(A_MINSTRET);
    total++; if (csr_rdata_o !== 64'h101) begin bad++; $display("FAIL minstret_inc got=%h want=%h", csr_rdata_o, 64'h101); end
    step();
    rd(A_MINSTRET);
    total++; if (csr_rdata_o !== 64'h101) begin bad++; $display("FAIL minstret_hold got=%h want=%h", csr_rdata_o, 64'h101); end
  endtask

  task automatic test_reset_mid_redirect();
    exc_valid_i = 1'b1; exc_cause_i = 4'd5; exc_pc_i = 64'h10; exc_tval_i = 64'h7;
    step();
    exc_valid_i = 1'b0;
    total++; if (redirect_valid_o !== 1'b1) begin bad++; $display("FAIL pre_rst_pulse got=%b want=1", redirect_valid_o); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (redirect_valid_o !== 1'b0 || redirect_pc_o !== 64'h0) begin bad++; $display("FAIL rst_abort got=%b/%h want=0/0", redirect_valid_o, redirect_pc_o); end
    rd(A_MSTATUS);
    total++; if (csr_rdata_o !== 64'h1800) begin bad++; $display("FAIL rst2_mstatus got=%h want=%h", csr_rdata_o, 64'h1800); end
    rd(A_MTVEC);
    total++; if (csr_rdata_o !== 64'h0) begin bad++; $display("FAIL rst2_mtvec got=%h want=0", csr_rdata_o); end
    rd(A_MEPC);
    total++; if (csr_rdata_o !== 64'h0) begin bad++; $display("FAIL rst2_mepc got=%h want=0", csr_rdata_o); end
    rd(A_MCAUSE);
    total++; if (csr_rdata_o !== 64'h0) begin bad++; $display("FAIL rst2_mcause got=%h want=0", csr_rdata_o); end
    rd(A_MINSTRET);
    total++; if (csr_rdata_o !== 64'h0) begin bad++; $display("FAIL rst2_minstret got=%h want=0", csr_rdata_o); end
    step();
    total++; if (redirect_valid_o !== 1'b0) begin bad++; $display("FAIL rst2_no_pulse got=%b want=0", redirect_valid_o); end
  endtask

  initial begin
    test_reset();
    test_csr_ops();
    test_interrupt();
    test_exception();
    test_mret();
    test_back_to_back();
    test_counters();
    test_reset_mid_redirect();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/csr_trap_unit.md
CSR_TRAP_UNIT -- requirements
Module: csr_trap_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning data width of all CSRs and PCs; legal values 32, 64.
REQ-002 SHALL have parameter HARTID, default 0, meaning value returned by mhartid.
REQ-003 SHALL have parameter MTVEC_RST, default 0, meaning mtvec reset value.
REQ-004 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports csr_op_i in 2 (00 none, 01 RW, 10 RS, 11 RC); csr_addr_i in 12; csr_wdata_i in XLEN.
REQ-007 SHALL have ports csr_rdata_o out XLEN (old CSR value) and csr_illegal_o out 1.
REQ-008 SHALL have ports retire_i in 1, instruction retired this cycle.
REQ-009 SHALL have ports exc_valid_i in 1, exc_cause_i in 4, exc_pc_i in XLEN, exc_tval_i in XLEN.
REQ-010 SHALL have ports mret_i in 1; int_ok_i in 1 (instruction boundary); int_pc_i in XLEN.
REQ-011 SHALL have ports msip_i, mtip_i, meip_i, each in 1, level interrupt lines.
REQ-012 SHALL have ports redirect_valid_o out 1, redirect_pc_o out XLEN, int_taken_o out 1.

Function
REQ-013 SHALL implement mstatus, mie, mip, mtvec, mepc, mcause, mtval, mcycle (0xB00), minstret (0xB02), mhartid; other address with op!=00 SHALL assert csr_illegal_o combinationally, no state change.
REQ-014 SHALL compute new value: RW = wdata; RS = old|wdata; RC = old&~wdata; write happens only if op=RW, or op=RS/RC with wdata!=0.
REQ-015 SHALL treat mhartid and mip as read-only: an actual write asserts csr_illegal_o and is discarded; RS/RC with wdata=0 is legal.
REQ-016 SHALL mask writes: mstatus writable bits MIE[3], MPIE[7] only, MPP[12:11] reads 11 always; mie writable bits 3, 7, 11 only; mepc bit0 forced 0; mtvec[1] forced 0.
REQ-017 SHALL register mip[3]=msip_i, mip[7]=mtip_i, mip[11]=meip_i every cycle; other bits 0.
REQ-018 SHALL increment mcycle every cycle and minstret on retire_i, modulo 2^XLEN; a CSR write to a counter in that cycle wins over the increment.
REQ-019 SHALL drive csr_rdata_o combinationally with current register contents (pre-write value).
REQ-020 SHALL evaluate pending = mstatus.MIE & |(mie & mip); interrupt taken when pending & int_ok_i & ~exc_valid_i & state=IDLE.
REQ-021 SHALL prioritise interrupt cause MEI(11) > MSI(3) > MTI(7).
REQ-022 SHALL prioritise same-cycle events: exception > interrupt > mret > CSR write; lower events that cycle are discarded (CSR write dropped, csr_illegal_o still computed).
REQ-023 SHALL on trap entry set mepc = pc & ~1 (exc_pc_i or int_pc_i), mcause = {interrupt bit at XLEN-1, code zero-extended}, mtval = exc_tval_i (0 for interrupts), MPIE = MIE, MIE = 0.
REQ-024 SHALL on mret set MIE = MPIE, MPIE = 1.
REQ-025 SHALL compute target: exception or mtvec[0]=0 -> {mtvec[XLEN-1:2],00}; interrupt with mtvec[0]=1 -> base + 4*code; mret -> mepc.
REQ-026 SHALL implement FSM IDLE/REDIRECT: IDLE -> REDIRECT on trap or mret, registering target into redirect_pc_o; REDIRECT asserts redirect_valid_o for exactly one cycle (int_taken_o also, if interrupt), then returns to IDLE.
REQ-027 SHALL ignore exc_valid_i, mret_i, interrupts and CSR writes while in REDIRECT (pipeline is flushing); counters keep running.

Reset
REQ-028 SHALL on rst set mstatus=0x1800, mie=0, mip=0, mtvec=MTVEC_RST, mepc=mcause=mtval=mcycle=minstret=0, FSM=IDLE, redirect_valid_o=0, redirect_pc_o=0, int_taken_o=0.
REQ-029 SHALL abort an in-progress REDIRECT when rst asserts mid-operation; no redirect pulse after reset.

Verification
REQ-030 SHALL cover: RW mstatus=0xFFFF_FFFF -> read back 0x1888; RC with 0x8 -> 0x1880; RS mhartid wdata=0 -> legal, wdata=1 -> csr_illegal_o=1, value unchanged.
REQ-031 SHALL cover: mtvec=0x1001, mie=0x80, MIE=1, mtip_i=1, int_ok_i=1, int_pc_i=0x2000 -> next cycle redirect_pc_o=0x101C, int_taken_o=1, mepc=0x2000, mcause MSB=1 code 7, MIE=0, MPIE=1.
REQ-032 SHALL cover: exc_valid_i with cause 2 and pending interrupt same cycle -> exception taken, redirect_pc_o=0x1000, mcause=2, mtval=exc_tval_i.
REQ-033 SHALL cover: mret with mepc=0x2000, MPIE=1 -> redirect_pc_o=0x2000, MIE=1; mret during REDIRECT ignored.
REQ-034 SHALL cover: write mcycle=all-ones then idle -> wraps to 0 next cycle; retire_i plus minstret write same cycle -> written value kept.
REQ-035 SHALL cover: rst asserted during REDIRECT -> redirect_valid_o=0 following cycle, all CSRs at reset values.
